// File: rtl/vram_scanout_if.sv
//------------------------------------------------------------------------------
// Module  : vram_scanout_if
// Brief   : Video RAM read-port bundle between the scan-out engine (master)
//           and the RAM read side (slave).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vram_scanout_if #(
   parameter int DATAW      = 24,
   parameter int addrLength = 20
);
   logic                  readEn;
   logic [addrLength-1:0] readPointer;
   logic [DATAW-1:0]      ramData;

   modport master (
      output readEn,
      output readPointer,
      input  ramData
   );

   modport slave (
      input  readEn,
      input  readPointer,
      output ramData
   );
endinterface

`default_nettype wire

// File: rtl/vram_scanout.sv
//------------------------------------------------------------------------------
// Module  : vram_scanout
// Brief   : VGA-style raster generator driving the video RAM read port one
//           pixel ahead, with a 2-stage aligned pixel/sync/de output pipeline.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vram_scanout #(
   parameter int DATAW      = 24,
   parameter int addrLength = 20,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit SYNC_POL   = 1'b0
) (
   input  logic              pixelClk,
   input  logic              resetN,
   input  logic              enable,
   vram_scanout_if.master    ram,
   output logic [DATAW-1:0]  rgbOut,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              frameStart
);

   localparam int c_hTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_vTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_hWidth = $clog2(c_hTotal);
   localparam int c_vWidth = $clog2(c_vTotal);

   localparam logic [c_hWidth-1:0] c_hOne       = c_hWidth'(1);
   localparam logic [c_hWidth-1:0] c_hLast      = c_hWidth'(c_hTotal - 1);
   localparam logic [c_hWidth-1:0] c_hActive    = c_hWidth'(H_ACTIVE);
   localparam logic [c_hWidth-1:0] c_hSyncStart = c_hWidth'(H_ACTIVE + H_FP);
   localparam logic [c_hWidth-1:0] c_hSyncEnd   = c_hWidth'(H_ACTIVE + H_FP + H_SYNC - 1);

   localparam logic [c_vWidth-1:0] c_vOne       = c_vWidth'(1);
   localparam logic [c_vWidth-1:0] c_vLast      = c_vWidth'(c_vTotal - 1);
   localparam logic [c_vWidth-1:0] c_vActive    = c_vWidth'(V_ACTIVE);
   localparam logic [c_vWidth-1:0] c_vSyncStart = c_vWidth'(V_ACTIVE + V_FP);
   localparam logic [c_vWidth-1:0] c_vSyncEnd   = c_vWidth'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic [addrLength-1:0] c_addrOne  = addrLength'(1);

   logic [c_hWidth-1:0]   r_hCount;
   logic [c_vWidth-1:0]   r_vCount;
   logic [addrLength-1:0] r_addr;

   logic r_de1;
   logic r_hs1;
   logic r_vs1;
   logic r_fs1;

   logic w_active;
   logic w_hLast;
   logic w_vLast;
   logic w_hSync;
   logic w_vSync;
   logic w_origin;
   logic w_readEn;

   assign w_active = (r_hCount < c_hActive) && (r_vCount < c_vActive);
   assign w_hLast  = (r_hCount == c_hLast);
   assign w_vLast  = (r_vCount == c_vLast);
   assign w_hSync  = (r_hCount >= c_hSyncStart) && (r_hCount <= c_hSyncEnd);
   assign w_vSync  = (r_vCount >= c_vSyncStart) && (r_vCount <= c_vSyncEnd);
   assign w_origin = (r_hCount == '0) && (r_vCount == '0);

   // resetN is folded in so the read strobe is quiet while reset is held,
   // even when enable is already high and the raster sits at (0,0).
   assign w_readEn = resetN & enable & w_active;

   assign ram.readEn      = w_readEn;
   assign ram.readPointer = r_addr;

   // Raster counters: held at origin while disabled, h wraps into v.
   always_ff @(posedge pixelClk or negedge resetN) begin
      if (!resetN) begin
         r_hCount <= '0;
         r_vCount <= '0;
      end else if (!enable) begin
         r_hCount <= '0;
         r_vCount <= '0;
      end else if (w_hLast) begin
         r_hCount <= '0;
         r_vCount <= w_vLast ? '0 : r_vCount + c_vOne;
      end else begin
         r_hCount <= r_hCount + c_hOne;
      end
   end

   // Running row-major read address: steps on active pixels, clears at frame wrap.
   always_ff @(posedge pixelClk or negedge resetN) begin
      if (!resetN) begin
         r_addr <= '0;
      end else if (!enable) begin
         r_addr <= '0;
      end else if (w_hLast && w_vLast) begin
         r_addr <= '0;
      end else if (w_active) begin
         r_addr <= r_addr + c_addrOne;
      end
   end

   // Stage 1: carry raster flags alongside the RAM read latency.
   always_ff @(posedge pixelClk or negedge resetN) begin
      if (!resetN) begin
         r_de1 <= 1'b0;
         r_hs1 <= 1'b0;
         r_vs1 <= 1'b0;
         r_fs1 <= 1'b0;
      end else begin
         r_de1 <= w_readEn;
         r_hs1 <= w_hSync;
         r_vs1 <= w_vSync;
         r_fs1 <= enable & w_origin;
      end
   end

   // Stage 2: register pixel and flags together so all pins stay aligned.
   always_ff @(posedge pixelClk or negedge resetN) begin
      if (!resetN) begin
         rgbOut     <= '0;
         de         <= 1'b0;
         hsync      <= ~SYNC_POL;
         vsync      <= ~SYNC_POL;
         frameStart <= 1'b0;
      end else begin
         rgbOut     <= r_de1 ? ram.ramData : '0;
         de         <= r_de1;
         hsync      <= r_hs1 ? SYNC_POL : ~SYNC_POL;
         vsync      <= r_vs1 ? SYNC_POL : ~SYNC_POL;
         frameStart <= r_fs1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vram_scanout.sv
//------------------------------------------------------------------------------
// Module  : tb_vram_scanout
// Brief   : Self-checking bench for vram_scanout: a default-timing instance and
//           a reduced-timing instance (active-high sync) against a raster model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vram_scanout;

   // Timing numbers written out from the raster rules (active, sync window).
   localparam int A_HA = 640, A_HT = 800, A_HSS = 656, A_HSE = 751;
   localparam int A_VA = 480, A_VT = 525, A_VSS = 490, A_VSE = 491;
   localparam int B_HA = 4,   B_HT = 8,   B_HSS = 5,   B_HSE = 6;
   localparam int B_VA = 3,   B_VT = 6,   B_VSS = 4,   B_VSE = 4;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [23:0] rgb;
   } outRec_t;

   logic pixelClk = 1'b0;
   logic resetN   = 1'b0;
   logic enA      = 1'b0;
   logic enB      = 1'b0;

   logic [23:0] rgbA;
   logic        hsA, vsA, deA, fsA;
   logic [7:0]  rgbB;
   logic        hsB, vsB, deB, fsB;

   int checks   = 0;
   int failures = 0;

   always #5 pixelClk = ~pixelClk;

   vram_scanout_if #(.DATAW(24), .addrLength(20)) ramA ();
   vram_scanout_if #(.DATAW(8),  .addrLength(4))  ramB ();

   vram_scanout #(
      .DATAW(24), .addrLength(20),
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
      .SYNC_POL(1'b0)
   ) dutA (
      .pixelClk(pixelClk), .resetN(resetN), .enable(enA), .ram(ramA),
      .rgbOut(rgbA), .hsync(hsA), .vsync(vsA), .de(deA), .frameStart(fsA)
   );

   vram_scanout #(
      .DATAW(8), .addrLength(4),
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b1)
   ) dutB (
      .pixelClk(pixelClk), .resetN(resetN), .enable(enB), .ram(ramB),
      .rgbOut(rgbB), .hsync(hsB), .vsync(vsB), .de(deB), .frameStart(fsB)
   );

   // RAM contents as a pure function of address.
   function automatic logic [23:0] memA(input logic [19:0] a);
      return {4'h0, a};
   endfunction

   function automatic logic [7:0] memB(input logic [3:0] a);
      return {a, ~a};
   endfunction

   // One-cycle-latency RAM read ports.
   always @(posedge pixelClk or negedge resetN) begin
      if (!resetN) begin
         ramA.ramData <= '0;
         ramB.ramData <= '0;
      end else begin
         if (ramA.readEn) ramA.ramData <= memA(ramA.readPointer);
         if (ramB.readEn) ramB.ramData <= memB(ramB.readPointer);
      end
   end

   // Pixels already consumed in the frame before raster index t.
   function automatic int ptrOf(input int t, input int ha, input int ht, input int va);
      int h;
      int v;
      h = t % ht;
      v = t / ht;
      if (v >= va) return va * ha;
      return v * ha + ((h < ha) ? h : ha);
   endfunction

   function automatic bit activeOf(input int t, input int ha, input int ht, input int va);
      return ((t % ht) < ha) && ((t / ht) < va);
   endfunction

   function automatic outRec_t recA(input int t, input logic en);
      outRec_t r;
      int h;
      int v;
      h     = t % A_HT;
      v     = t / A_HT;
      r.de  = en && activeOf(t, A_HA, A_HT, A_VA);
      r.hs  = (h >= A_HSS) && (h <= A_HSE);
      r.vs  = (v >= A_VSS) && (v <= A_VSE);
      r.fs  = en && (t == 0);
      r.rgb = r.de ? memA(20'(ptrOf(t, A_HA, A_HT, A_VA))) : 24'h0;
      return r;
   endfunction

   function automatic outRec_t recB(input int t, input logic en);
      outRec_t r;
      int h;
      int v;
      h     = t % B_HT;
      v     = t / B_HT;
      r.de  = en && activeOf(t, B_HA, B_HT, B_VA);
      r.hs  = (h >= B_HSS) && (h <= B_HSE);
      r.vs  = (v >= B_VSS) && (v <= B_VSE);
      r.fs  = en && (t == 0);
      r.rgb = r.de ? {16'h0, memB(4'(ptrOf(t, B_HA, B_HT, B_VA)))} : 24'h0;
      return r;
   endfunction

   // Model state: raster index since the last (re)start, plus a 2-deep output delay.
   int      tA, tB;
   outRec_t pA1, pA2, pB1, pB2;

   always @(posedge pixelClk or negedge resetN) begin
      if (!resetN) begin
         tA  <= 0;
         tB  <= 0;
         pA1 <= '0;
         pA2 <= '0;
         pB1 <= '0;
         pB2 <= '0;
      end else begin
         pA2 <= pA1;
         pA1 <= recA(tA, enA);
         tA  <= enA ? (tA + 1) % (A_HT * A_VT) : 0;
         pB2 <= pB1;
         pB1 <= recB(tB, enB);
         tB  <= enB ? (tB + 1) % (B_HT * B_VT) : 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 50)
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model while out of reset.
   always @(negedge pixelClk) begin
      if (resetN) begin
         chk("A.readEn",      32'(ramA.readEn),      32'(enA && activeOf(tA, A_HA, A_HT, A_VA)));
         chk("A.readPointer", 32'(ramA.readPointer), ptrOf(tA, A_HA, A_HT, A_VA));
         chk("A.rgbOut",      32'(rgbA),             32'(pA2.rgb));
         chk("A.de",          32'(deA),              32'(pA2.de));
         chk("A.hsync",       32'(hsA),              32'(!pA2.hs));
         chk("A.vsync",       32'(vsA),              32'(!pA2.vs));
         chk("A.frameStart",  32'(fsA),              32'(pA2.fs));
         chk("B.readEn",      32'(ramB.readEn),      32'(enB && activeOf(tB, B_HA, B_HT, B_VA)));
         chk("B.readPointer", 32'(ramB.readPointer), ptrOf(tB, B_HA, B_HT, B_VA));
         chk("B.rgbOut",      32'(rgbB),             32'(pB2.rgb));
         chk("B.de",          32'(deB),              32'(pB2.de));
         chk("B.hsync",       32'(hsB),              32'(pB2.hs));
         chk("B.vsync",       32'(vsB),              32'(pB2.vs));
         chk("B.frameStart",  32'(fsB),              32'(pB2.fs));
      end
   end

   task automatic chkResetValues(input string tag);
      chk({tag, ".A.readEn"},      32'(ramA.readEn),      32'h0);
      chk({tag, ".A.readPointer"}, 32'(ramA.readPointer), 32'h0);
      chk({tag, ".A.rgbOut"},      32'(rgbA),             32'h0);
      chk({tag, ".A.de"},          32'(deA),              32'h0);
      chk({tag, ".A.frameStart"},  32'(fsA),              32'h0);
      chk({tag, ".A.hsync"},       32'(hsA),              32'h1);
      chk({tag, ".A.vsync"},       32'(vsA),              32'h1);
      chk({tag, ".B.readEn"},      32'(ramB.readEn),      32'h0);
      chk({tag, ".B.rgbOut"},      32'(rgbB),             32'h0);
      chk({tag, ".B.hsync"},       32'(hsB),              32'h0);
      chk({tag, ".B.vsync"},       32'(vsB),              32'h0);
   endtask

   // Directed stimulus with hand-computed expectations; cycle 0 = enable rise.
   initial begin
      repeat (3) @(posedge pixelClk);
      @(negedge pixelClk);
      chkResetValues("por");
      @(posedge pixelClk); #1;
      resetN = 1'b1;
      @(posedge pixelClk); #1;

      for (int c = 0; c <= 4250; c++) begin
         if (c == 0) begin
            enA = 1'b1;
            enB = 1'b1;
         end
         if (c == 4100) enA = 1'b0;
         if (c == 4150) enA = 1'b1;
         @(negedge pixelClk);
         case (c)
            0:    begin
                     chk("lit.A.ptr0",   32'(ramA.readPointer), 32'd0);
                     chk("lit.A.rden0",  32'(ramA.readEn),      32'd1);
                     chk("lit.B.ptr0",   32'(ramB.readPointer), 32'd0);
                  end
            2:    begin
                     chk("lit.A.de2",    32'(deA),  32'd1);
                     chk("lit.A.rgb2",   32'(rgbA), 32'd0);
                     chk("lit.A.fs2",    32'(fsA),  32'd1);
                     chk("lit.B.fs2",    32'(fsB),  32'd1);
                     chk("lit.B.rgb2",   32'(rgbB), 32'h0F);
                  end
            3:    chk("lit.A.fs3",       32'(fsA),  32'd0);
            6:    chk("lit.B.hs6",       32'(hsB),  32'd0);
            7:    chk("lit.B.hs7",       32'(hsB),  32'd1);
            9:    chk("lit.B.hs9",       32'(hsB),  32'd0);
            19:   chk("lit.B.ptr19",     32'(ramB.readPointer), 32'd11);
            20:   begin
                     chk("lit.B.ptr20",  32'(ramB.readPointer), 32'd12);
                     chk("lit.B.rden20", 32'(ramB.readEn),      32'd0);
                  end
            21:   begin
                     chk("lit.B.de21",   32'(deB),  32'd1);
                     chk("lit.B.rgb21",  32'(rgbB), 32'hB4);
                  end
            33:   chk("lit.B.vs33",      32'(vsB),  32'd0);
            34:   chk("lit.B.vs34",      32'(vsB),  32'd1);
            41:   chk("lit.B.vs41",      32'(vsB),  32'd1);
            42:   chk("lit.B.vs42",      32'(vsB),  32'd0);
            47:   chk("lit.B.ptr47",     32'(ramB.readPointer), 32'd12);
            48:   begin
                     chk("lit.B.ptr48",  32'(ramB.readPointer), 32'd0);
                     chk("lit.B.rden48", 32'(ramB.readEn),      32'd1);
                  end
            50:   chk("lit.B.fs50",      32'(fsB),  32'd1);
            146:  chk("lit.B.fs146",     32'(fsB),  32'd1);
            639:  chk("lit.A.ptr639",    32'(ramA.readPointer), 32'd639);
            640:  begin
                     chk("lit.A.rden640", 32'(ramA.readEn),      32'd0);
                     chk("lit.A.ptr640",  32'(ramA.readPointer), 32'd640);
                  end
            641:  begin
                     chk("lit.A.de641",  32'(deA),  32'd1);
                     chk("lit.A.rgb641", 32'(rgbA), 32'd639);
                  end
            642:  begin
                     chk("lit.A.de642",  32'(deA),  32'd0);
                     chk("lit.A.rgb642", 32'(rgbA), 32'd0);
                  end
            657:  chk("lit.A.hs657",     32'(hsA),  32'd1);
            658:  chk("lit.A.hs658",     32'(hsA),  32'd0);
            753:  chk("lit.A.hs753",     32'(hsA),  32'd0);
            754:  chk("lit.A.hs754",     32'(hsA),  32'd1);
            800:  begin
                     chk("lit.A.ptr800",  32'(ramA.readPointer), 32'd640);
                     chk("lit.A.rden800", 32'(ramA.readEn),      32'd1);
                  end
            1000: chk("lit.A.vs1000",    32'(vsA),  32'd1);
            1458: chk("lit.A.hs1458",    32'(hsA),  32'd0);
            1600: chk("lit.A.ptr1600",   32'(ramA.readPointer), 32'd1280);
            4100: begin
                     chk("lit.A.rden4100", 32'(ramA.readEn),      32'd0);
                     chk("lit.A.ptr4100",  32'(ramA.readPointer), 32'd3300);
                  end
            4101: begin
                     chk("lit.A.de4101",  32'(deA),  32'd1);
                     chk("lit.A.rgb4101", 32'(rgbA), 32'd3299);
                  end
            4102: begin
                     chk("lit.A.de4102",  32'(deA),  32'd0);
                     chk("lit.A.rgb4102", 32'(rgbA), 32'd0);
                  end
            4103: chk("lit.A.ptr4103",   32'(ramA.readPointer), 32'd0);
            4150: begin
                     chk("lit.A.ptr4150",  32'(ramA.readPointer), 32'd0);
                     chk("lit.A.rden4150", 32'(ramA.readEn),      32'd1);
                  end
            4151: chk("lit.A.fs4151",    32'(fsA),  32'd0);
            4152: begin
                     chk("lit.A.fs4152",  32'(fsA),  32'd1);
                     chk("lit.A.de4152",  32'(deA),  32'd1);
                  end
            4250: begin
                     chk("lit.A.de4250",  32'(deA),  32'd1);
                     chk("lit.A.rgb4250", 32'(rgbA), 32'd98);
                     // Asynchronous reset mid-line, checked before any clock edge.
                     #1 resetN = 1'b0;
                     #1 chkResetValues("async");
                  end
            default: ;
         endcase
         @(posedge pixelClk); #1;
      end

      // Release reset with enable already high: scan restarts at the origin.
      @(posedge pixelClk); #1;
      resetN = 1'b1;
      @(negedge pixelClk);
      chk("rel.A.ptr",  32'(ramA.readPointer), 32'd0);
      chk("rel.A.rden", 32'(ramA.readEn),      32'd1);
      @(posedge pixelClk); #1;
      @(negedge pixelClk);
      chk("rel.A.fs1",  32'(fsA), 32'd0);
      @(posedge pixelClk); #1;
      @(negedge pixelClk);
      chk("rel.A.fs2",  32'(fsA), 32'd1);
      chk("rel.A.de2",  32'(deA), 32'd1);
      chk("rel.B.fs2",  32'(fsB), 32'd1);
      repeat (60) @(posedge pixelClk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
